// File: rtl/multiplier_booths.sv
// Sequential signed multiplier, radix-2 Booth recoding, one add/sub-and-shift step per clock.
// The accumulator carries one guard bit so negating the most-negative multiplicand cannot overflow.
module multiplier_booths #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 load,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [WIDTH:0]    m_q;
  logic [WIDTH:0]    a_q;
  logic [WIDTH-1:0]  q_q;
  logic              q1_q;
  logic [CntW-1:0]   count_q;

  logic [WIDTH:0]    sum;
  logic [WIDTH:0]    a_shift;
  logic [WIDTH-1:0]  q_shift;

  // Booth step: recode {Q[0], q_1}, then arithmetic shift of {A, Q, q_1}.
  always_comb begin
    case ({q_q[0], q1_q})
      2'b01:   sum = a_q + m_q;
      2'b10:   sum = a_q - m_q;
      default: sum = a_q;
    endcase
    a_shift = {sum[WIDTH], sum[WIDTH:1]};
    q_shift = {sum[0], q_q[WIDTH-1:1]};
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= StIdle;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      count_q <= '0;
      product <= '0;
      done    <= 1'b0;
    end else if (load) begin
      state_q <= StRun;
      m_q     <= {multiplicand[WIDTH-1], multiplicand};
      a_q     <= '0;
      q_q     <= multiplier;
      q1_q    <= 1'b0;
      count_q <= CntW'(WIDTH);
      done    <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          a_q     <= a_shift;
          q_q     <= q_shift;
          q1_q    <= q_q[0];
          count_q <= count_q - CntW'(1);
          if (count_q == CntW'(1)) begin
            product <= {a_shift[WIDTH-1:0], q_shift};
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_booths.sv
// Directed and exhaustive checks of the Booth multiplier: latency, results, abort, restart, hold.
module tb_multiplier_booths;

  logic       clock;
  logic       clear;
  logic       load;
  logic [3:0] multiplicand;
  logic [3:0] multiplier;
  logic [7:0] product;
  logic       done;

  int checks;
  int failures;

  typedef struct {
    logic [3:0] m;
    logic [3:0] q;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[9];

  multiplier_booths #(.WIDTH(4)) dut (
    .clock        (clock),
    .clear        (clear),
    .load         (load),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .done         (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Load for one edge, then expect done exactly WIDTH edges after load drops.
  task automatic do_mul(input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp,
                        input string name);
    multiplicand = m;
    multiplier   = q;
    load         = 1'b1;
    tick();
    check({name, "_done_at_load"}, 16'(done), 16'd0);
    load = 1'b0;
    repeat (3) tick();
    check({name, "_done_early"}, 16'(done), 16'd0);
    tick();
    check({name, "_done"}, 16'(done), 16'd1);
    check({name, "_product"}, 16'(product), 16'(exp));
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    clear        = 1'b1;
    load         = 1'b0;
    multiplicand = 4'h0;
    multiplier   = 4'h0;

    vecs[0] = '{m: 4'h5, q: 4'h6, exp: 8'h1E};
    vecs[1] = '{m: 4'hD, q: 4'h7, exp: 8'hEB};
    vecs[2] = '{m: 4'hB, q: 4'hB, exp: 8'h19};
    vecs[3] = '{m: 4'h0, q: 4'h9, exp: 8'h00};
    vecs[4] = '{m: 4'h8, q: 4'h8, exp: 8'h40};
    vecs[5] = '{m: 4'h8, q: 4'h7, exp: 8'hC8};
    vecs[6] = '{m: 4'h7, q: 4'h7, exp: 8'h31};
    vecs[7] = '{m: 4'hF, q: 4'hF, exp: 8'h01};
    vecs[8] = '{m: 4'h3, q: 4'hC, exp: 8'hF4};

    // Reset, then 3 * -4 with load held for two edges.
    repeat (2) tick();
    check("reset_product", 16'(product), 16'h0);
    check("reset_done", 16'(done), 16'd0);
    clear        = 1'b0;
    multiplicand = 4'h3;
    multiplier   = 4'hC;
    load         = 1'b1;
    repeat (2) tick();
    check("basic_done_at_load", 16'(done), 16'd0);
    load = 1'b0;
    repeat (3) tick();
    check("basic_done_early", 16'(done), 16'd0);
    tick();
    check("basic_done", 16'(done), 16'd1);
    check("basic_product", 16'(product), 16'hF4);
    clear = 1'b1;
    tick();
    check("clear_product", 16'(product), 16'h0);
    check("clear_done", 16'(done), 16'd0);
    clear = 1'b0;
    repeat (3) tick();
    check("idle_done", 16'(done), 16'd0);

    // Directed sign combinations and extremes.
    for (int i = 0; i < 9; i++) begin
      do_mul(vecs[i].m, vecs[i].q, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Exhaustive sweep against a signed reference product.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        logic [3:0] mi;
        logic [3:0] qj;
        int         ref_p;
        mi    = i[3:0];
        qj    = j[3:0];
        ref_p = int'($signed(mi)) * int'($signed(qj));
        do_mul(mi, qj, ref_p[7:0], $sformatf("sweep_%h_%h", mi, qj));
      end
    end

    // Abort: clear on the second RUN edge.
    clear = 1'b1;
    tick();
    clear        = 1'b0;
    multiplicand = 4'h3;
    multiplier   = 4'hC;
    load         = 1'b1;
    tick();
    load = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("abort_done", 16'(done), 16'd0);
    check("abort_product", 16'(product), 16'h0);
    repeat (5) tick();
    check("abort_done_later", 16'(done), 16'd0);
    check("abort_product_later", 16'(product), 16'h0);

    // Restart: new load mid-RUN replaces the operation in flight.
    multiplicand = 4'h3;
    multiplier   = 4'hC;
    load         = 1'b1;
    tick();
    load = 1'b0;
    repeat (2) tick();
    multiplicand = 4'h2;
    multiplier   = 4'h3;
    load         = 1'b1;
    tick();
    load = 1'b0;
    repeat (3) tick();
    check("restart_done_early", 16'(done), 16'd0);
    tick();
    check("restart_done", 16'(done), 16'd1);
    check("restart_product", 16'(product), 16'h06);

    // Hold: operand changes without load leave the result alone.
    for (int k = 0; k < 12; k++) begin
      multiplicand = 4'(k + 5);
      multiplier   = 4'(3 * k);
      tick();
      check($sformatf("hold_done_%0d", k), 16'(done), 16'd1);
      check($sformatf("hold_product_%0d", k), 16'(product), 16'h06);
    end

    // Operands changing during RUN are ignored.
    multiplicand = 4'h5;
    multiplier   = 4'h6;
    load         = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      multiplicand = 4'(k + 9);
      multiplier   = 4'(7 - k);
      tick();
    end
    check("isolate_done", 16'(done), 16'd1);
    check("isolate_product", 16'(product), 16'h1E);

    // Long load: five edges of load, done only four edges after release.
    multiplicand = 4'h3;
    multiplier   = 4'hC;
    load         = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("longload_done_%0d", k), 16'(done), 16'd0);
    end
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("longload_run_%0d", k), 16'(done), 16'd0);
    end
    tick();
    check("longload_done", 16'(done), 16'd1);
    check("longload_product", 16'(product), 16'hF4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
